nv_nvdla_cacc_grp_reg: RTL and testbench
========================================

# nv_nvdla_cacc_grp_reg

- Parametrised N-group register file for the CACC convolution accumulator. Generalises the two-group (ping-pong) layer-configuration scheme to `NUM_GROUPS` groups.
- Software programs the group selected by a producer pointer while the datapath consumes groups in round-robin order. Progress is tracked by a per-group op_enable state machine.
- Sits between the CSB register decoder and the CACC datapath. It drives the active (consumer) group's configuration and `op_en`, and latches per-op saturation counts.

## Interface
- `NUM_GROUPS`, 2 — number of register groups, 2..4.
- `PTR_W`, 1 — pointer width, equal to clog2(`NUM_GROUPS`).
- `CH_W`, 13 — width of `dataout_width`, `dataout_height` and `dataout_channel`, 13..15.
- Clock and reset: one clock; reset is synchronous and active-low.
- `nvdla_core_clk`  in  1  core clock.
- `nvdla_core_rstn`  in  1  synchronous active-low reset.
- `reg_offset`  in  12  register byte offset.
- `reg_wr_en`  in  1  write strobe, single cycle.
- `reg_wr_data`  in  32  write data.
- `reg_rd_data`  out  32  read data; combinational from `reg_offset`.
- `dp_op_done`  in  1  pulse from the datapath: the consumer group's op has finished.
- `sat_count`  in  32  saturation count for the finishing op; sampled with `dp_op_done`.
- `op_en`  out  1  consumer group op_enable; registered.
- `consumer`  out  `PTR_W`  index of the active group.
- `done_intr`  out  1  one-cycle pulse, one cycle after `dp_op_done` is accepted.
- `done_grp`  out  `PTR_W`  index of the group that finished; valid with `done_intr`.
- Configuration outputs of the consumer group: `conv_mode`[1], `proc_precision`[2], `dataout_width`/`dataout_height`/`dataout_channel`[`CH_W`], `dataout_addr`[27], `batches`[5], `line_stride`[24], `surf_stride`[24], `line_packed`[1], `surf_packed`[1], `clip_truncate`[5], `cya`[32].

## Operation
Single (ungrouped) registers:
- 0x000 POINTER: producer index in [`PTR_W`-1:0], R/W; consumer index in [16+`PTR_W`-1:16], RO.
- 0x004 STATUS, RO except the sticky bit:
  - group g state at bits [2g+1:2g]: 0 = IDLE, 1 = PEND, 2 = RUN.
  - bit 31 `wr_err`: sticky; cleared by writing 1 to bit 31.

Group registers:
- Offsets and field placement per group:
  - 0x008 OP_ENABLE bit0.
  - 0x00c MISC_CFG: `conv_mode` bit0; `proc_precision` [13:12], reset 2'b01.
  - 0x010 SIZE_0: width [CH_W-1:0], height [16+CH_W-1:16].
  - 0x014 SIZE_1: channel.
  - 0x018 ADDR [31:5].
  - 0x01c BATCH [4:0].
  - 0x020 LINE_STRIDE [23:0].
  - 0x024 SURF_STRIDE [23:0].
  - 0x028 MAP: bits 0 and 16.
  - 0x02c CLIP [4:0].
  - 0x030 SAT (RO).
  - 0x034 CYA.
- Reads and writes at these offsets address group `producer`. Unmapped offsets read 0; writes to them and to RO fields are ignored.
- Per-group state machine:
  - IDLE -> PEND: write OP_ENABLE bit0 = 1.
  - PEND -> RUN: when g == `consumer`.
  - RUN -> IDLE: on `dp_op_done`.
  - A group is locked while in PEND or RUN.
  - Writing OP_ENABLE = 0 never clears the state.
- Lock rule: writes to a locked group, at any offset including OP_ENABLE, are dropped and set `wr_err`. Lock is evaluated on pre-edge state.
- On `dp_op_done` while the consumer group is in RUN:
  - consumer state -> IDLE;
  - SAT[consumer] <= `sat_count`;
  - `consumer` <= (`consumer` + 1) mod `NUM_GROUPS`;
  - `done_intr` = 1 and `done_grp` = old consumer on the next cycle.
- `dp_op_done` while the consumer group is not in RUN is ignored.
- `op_en` = 1 iff the consumer group is in RUN.
- Producer pointer writes wrap: value mod `NUM_GROUPS`, computed from the low `PTR_W` bits. With a power-of-two `NUM_GROUPS` this is plain truncation.

## Timing
- Register writes take effect at the next rising edge; configuration outputs update at the same edge.
- Reads are zero-latency.
- PEND -> RUN takes one cycle after the pointer or state condition holds; `op_en` rises one cycle after the OP_ENABLE write when that group is already the consumer.
- `dp_op_done` -> `op_en` low, `consumer` advance and `done_intr` all occur at the next edge. If the next group is already PEND, `op_en` rises again one cycle later.
- Simultaneous events:
  - `dp_op_done` with a write to the same group: the write is dropped because the group was locked.
  - `dp_op_done` with a write to another IDLE group: both take effect.
- Reset, including mid-operation:
  - all groups IDLE; `producer` = `consumer` = 0;
  - all fields 0, except `proc_precision` = 2'b01;
  - `op_en` = 0, `done_intr` = 0, `done_grp` = 0, `wr_err` = 0;
  - SAT = 0.

## Configuration
- Macro: `NVDLA_CACC_SAT_ACCUM_EN`.
- Defined: `dp_op_done` adds `sat_count` into SAT[g], saturating at 32'hffffffff. Any write to 0x030 of an unlocked group clears it.
- Undefined: SAT is overwritten with `sat_count` on each done. Writes to 0x030 are ignored.

## Test plan
- Reset, then read all offsets: 0x00c = 0x00001000; every other offset = 0; `op_en` = 0.
- `NUM_GROUPS` = 2:
  - write ADDR = 0xdead_bee0 to group 0, then set OP_ENABLE;
  - `dataout_addr` = 0x6f5_6df7 one cycle after the ADDR write; `op_en` = 1 two cycles after the OP_ENABLE write; STATUS = 0x2.
- While group 0 is in RUN, write POINTER = 0 and then CLIP = 5:
  - the write is dropped and STATUS bit31 = 1;
  - writing 0x80000000 to STATUS clears bit31.
- Group 1 is PEND while group 0 runs; pulse `dp_op_done` with `sat_count` = 7:
  - next cycle: `done_intr` = 1, `done_grp` = 0, `consumer` = 1, `op_en` = 0;
  - one cycle later `op_en` = 1;
  - SAT of group 0 reads 7.
- `NUM_GROUPS` = 4: run four ops back-to-back; `consumer` sequence is 0, 1, 2, 3, 0. `dp_op_done` while IDLE produces no `done_intr`.
- Macro defined: two ops on group 0 with `sat_count` = 0xffff_fff0 then 0x20; SAT reads 0xffff_ffff.

Source files
------------

// File: rtl/nv_nvdla_cacc_grp_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nv_nvdla_cacc_grp_reg: N-group CACC layer registers, round-robin consumer |
// | Option NVDLA_CACC_SAT_ACCUM_EN: SAT accumulates (saturating) per op.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module nv_nvdla_cacc_grp_reg #(
  parameter int NUM_GROUPS = 2,
  parameter int PTR_W      = 1,
  parameter int CH_W       = 13
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic [11:0]       reg_offset,
  input  logic              reg_wr_en,
  input  logic [31:0]       reg_wr_data,
  output logic [31:0]       reg_rd_data,
  input  logic              dp_op_done,
  input  logic [31:0]       sat_count,
  output logic              op_en,
  output logic [PTR_W-1:0]  consumer,
  output logic              done_intr,
  output logic [PTR_W-1:0]  done_grp,
  output logic              conv_mode,
  output logic [1:0]        proc_precision,
  output logic [CH_W-1:0]   dataout_width,
  output logic [CH_W-1:0]   dataout_height,
  output logic [CH_W-1:0]   dataout_channel,
  output logic [26:0]       dataout_addr,
  output logic [4:0]        batches,
  output logic [23:0]       line_stride,
  output logic [23:0]       surf_stride,
  output logic              line_packed,
  output logic              surf_packed,
  output logic [4:0]        clip_truncate,
  output logic [31:0]       cya
);

  localparam logic [11:0] c_ofs_pointer   = 12'h000;
  localparam logic [11:0] c_ofs_status    = 12'h004;
  localparam logic [11:0] c_ofs_op_enable = 12'h008;
  localparam logic [11:0] c_ofs_misc      = 12'h00c;
  localparam logic [11:0] c_ofs_size_0    = 12'h010;
  localparam logic [11:0] c_ofs_size_1    = 12'h014;
  localparam logic [11:0] c_ofs_addr      = 12'h018;
  localparam logic [11:0] c_ofs_batch     = 12'h01c;
  localparam logic [11:0] c_ofs_line_str  = 12'h020;
  localparam logic [11:0] c_ofs_surf_str  = 12'h024;
  localparam logic [11:0] c_ofs_map       = 12'h028;
  localparam logic [11:0] c_ofs_clip      = 12'h02c;
  localparam logic [11:0] c_ofs_sat       = 12'h030;
  localparam logic [11:0] c_ofs_cya       = 12'h034;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RUN  = 2'd2
  } grp_state_t;

  typedef struct packed {
    logic            conv_mode;
    logic [1:0]      precision;
    logic [CH_W-1:0] width;
    logic [CH_W-1:0] height;
    logic [CH_W-1:0] channel;
    logic [26:0]     addr;
    logic [4:0]      batches;
    logic [23:0]     line_stride;
    logic [23:0]     surf_stride;
    logic            line_packed;
    logic            surf_packed;
    logic [4:0]      clip;
    logic [31:0]     cya;
  } grp_cfg_t;

  logic [PTR_W-1:0] r_producer;
  logic [PTR_W-1:0] r_consumer;
  logic             r_op_en;
  logic             r_done_intr;
  logic [PTR_W-1:0] r_done_grp;
  logic             r_wr_err;

  logic                            w_grp_ofs;
  logic                            w_grp_wr;
  logic [NUM_GROUPS-1:0]           w_err_vec;
  logic [NUM_GROUPS-1:0]           w_done_vec;
  logic [NUM_GROUPS-1:0]           w_en_vec;
  logic [NUM_GROUPS-1:0][1:0]      w_grp_state;
  logic [NUM_GROUPS-1:0][31:0]     w_grp_sat;
  grp_cfg_t [NUM_GROUPS-1:0]       w_grp_cfg;
  logic                            w_done;
  logic [PTR_W-1:0]                w_ptr_raw;
  logic [PTR_W-1:0]                w_ptr_wrap;
  logic [PTR_W-1:0]                w_cons_next;
  grp_cfg_t                        w_p_cfg;
  logic [1:0]                      w_p_state;
  logic [31:0]                     w_p_sat;
  grp_cfg_t                        w_c_cfg;

  assign w_grp_ofs = (reg_offset >= c_ofs_op_enable) && (reg_offset <= c_ofs_cya) &&
                     (reg_offset[1:0] == 2'b00);
  assign w_grp_wr  = reg_wr_en && w_grp_ofs;
  assign w_done    = |w_done_vec;

  // Raw pointer is below 2*NUM_GROUPS, so one conditional subtract is a full modulo.
  assign w_ptr_raw   = reg_wr_data[PTR_W-1:0];
  assign w_ptr_wrap  = (int'(w_ptr_raw) >= NUM_GROUPS) ? (w_ptr_raw - PTR_W'(NUM_GROUPS)) : w_ptr_raw;
  assign w_cons_next = (r_consumer == PTR_W'(NUM_GROUPS - 1)) ? '0 : (r_consumer + PTR_W'(1));

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    grp_state_t  r_state;
    grp_cfg_t    r_cfg;
    logic [31:0] r_sat;
    logic        w_sel;
    logic        w_cons;
    logic        w_wr;

    assign w_sel  = (r_producer == PTR_W'(g));
    assign w_cons = (r_consumer == PTR_W'(g));
    // Lock is judged on the pre-edge state, so a write racing a done is still dropped.
    assign w_wr          = w_grp_wr && w_sel && (r_state == ST_IDLE);
    assign w_err_vec[g]  = w_grp_wr && w_sel && (r_state != ST_IDLE);
    assign w_done_vec[g] = dp_op_done && w_cons && (r_state == ST_RUN);
    assign w_en_vec[g]   = w_cons && ((r_state == ST_PEND) || ((r_state == ST_RUN) && !dp_op_done));

    assign w_grp_state[g] = r_state;
    assign w_grp_cfg[g]   = r_cfg;
    assign w_grp_sat[g]   = r_sat;

`ifdef NVDLA_CACC_SAT_ACCUM_EN
    logic [32:0] w_sat_sum;
    assign w_sat_sum = {1'b0, r_sat} + {1'b0, sat_count};
`endif

    always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
        r_state         <= ST_IDLE;
        r_cfg           <= '0;
        r_cfg.precision <= 2'b01;
        r_sat           <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_wr && (reg_offset == c_ofs_op_enable) && reg_wr_data[0]) r_state <= ST_PEND;
          ST_PEND: if (w_cons) r_state <= ST_RUN;
          ST_RUN:  if (w_done_vec[g]) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase

        if (w_wr) begin
          case (reg_offset)
            c_ofs_misc: begin
              r_cfg.conv_mode <= reg_wr_data[0];
              r_cfg.precision <= reg_wr_data[13:12];
            end
            c_ofs_size_0: begin
              r_cfg.width  <= reg_wr_data[CH_W-1:0];
              r_cfg.height <= reg_wr_data[16 +: CH_W];
            end
            c_ofs_size_1:   r_cfg.channel     <= reg_wr_data[CH_W-1:0];
            c_ofs_addr:     r_cfg.addr        <= reg_wr_data[31:5];
            c_ofs_batch:    r_cfg.batches     <= reg_wr_data[4:0];
            c_ofs_line_str: r_cfg.line_stride <= reg_wr_data[23:0];
            c_ofs_surf_str: r_cfg.surf_stride <= reg_wr_data[23:0];
            c_ofs_map: begin
              r_cfg.line_packed <= reg_wr_data[0];
              r_cfg.surf_packed <= reg_wr_data[16];
            end
            c_ofs_clip:     r_cfg.clip        <= reg_wr_data[4:0];
            c_ofs_cya:      r_cfg.cya         <= reg_wr_data;
`ifdef NVDLA_CACC_SAT_ACCUM_EN
            c_ofs_sat:      r_sat             <= '0;
`endif
            default: ;
          endcase
        end

        if (w_done_vec[g]) begin
`ifdef NVDLA_CACC_SAT_ACCUM_EN
          r_sat <= w_sat_sum[32] ? 32'hffff_ffff : w_sat_sum[31:0];
`else
          r_sat <= sat_count;
`endif
        end
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_producer  <= '0;
      r_consumer  <= '0;
      r_op_en     <= 1'b0;
      r_done_intr <= 1'b0;
      r_done_grp  <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      if (reg_wr_en && (reg_offset == c_ofs_pointer)) r_producer <= w_ptr_wrap;
      if (w_done) begin
        r_consumer <= w_cons_next;
        r_done_grp <= r_consumer;
      end
      r_op_en     <= |w_en_vec;
      r_done_intr <= w_done;
      if (|w_err_vec) r_wr_err <= 1'b1;
      else if (reg_wr_en && (reg_offset == c_ofs_status) && reg_wr_data[31]) r_wr_err <= 1'b0;
    end
  end

  always_comb begin
    w_p_cfg   = '0;
    w_p_state = '0;
    w_p_sat   = '0;
    w_c_cfg   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (r_producer == PTR_W'(g)) begin
        w_p_cfg   = w_grp_cfg[g];
        w_p_state = w_grp_state[g];
        w_p_sat   = w_grp_sat[g];
      end
      if (r_consumer == PTR_W'(g)) w_c_cfg = w_grp_cfg[g];
    end
  end

  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      c_ofs_pointer: begin
        reg_rd_data[PTR_W-1:0]  = r_producer;
        reg_rd_data[16 +: PTR_W] = r_consumer;
      end
      c_ofs_status: begin
        for (int g = 0; g < NUM_GROUPS; g++) reg_rd_data[2*g +: 2] = w_grp_state[g];
        reg_rd_data[31] = r_wr_err;
      end
      c_ofs_op_enable: reg_rd_data[0] = (w_p_state != 2'd0);
      c_ofs_misc: begin
        reg_rd_data[0]     = w_p_cfg.conv_mode;
        reg_rd_data[13:12] = w_p_cfg.precision;
      end
      c_ofs_size_0: begin
        reg_rd_data[CH_W-1:0]  = w_p_cfg.width;
        reg_rd_data[16 +: CH_W] = w_p_cfg.height;
      end
      c_ofs_size_1:   reg_rd_data[CH_W-1:0] = w_p_cfg.channel;
      c_ofs_addr:     reg_rd_data[31:5]     = w_p_cfg.addr;
      c_ofs_batch:    reg_rd_data[4:0]      = w_p_cfg.batches;
      c_ofs_line_str: reg_rd_data[23:0]     = w_p_cfg.line_stride;
      c_ofs_surf_str: reg_rd_data[23:0]     = w_p_cfg.surf_stride;
      c_ofs_map: begin
        reg_rd_data[0]  = w_p_cfg.line_packed;
        reg_rd_data[16] = w_p_cfg.surf_packed;
      end
      c_ofs_clip:     reg_rd_data[4:0]      = w_p_cfg.clip;
      c_ofs_sat:      reg_rd_data           = w_p_sat;
      c_ofs_cya:      reg_rd_data           = w_p_cfg.cya;
      default:        reg_rd_data           = '0;
    endcase
  end

  assign op_en           = r_op_en;
  assign consumer        = r_consumer;
  assign done_intr       = r_done_intr;
  assign done_grp        = r_done_grp;
  assign conv_mode       = w_c_cfg.conv_mode;
  assign proc_precision  = w_c_cfg.precision;
  assign dataout_width   = w_c_cfg.width;
  assign dataout_height  = w_c_cfg.height;
  assign dataout_channel = w_c_cfg.channel;
  assign dataout_addr    = w_c_cfg.addr;
  assign batches         = w_c_cfg.batches;
  assign line_stride     = w_c_cfg.line_stride;
  assign surf_stride     = w_c_cfg.surf_stride;
  assign line_packed     = w_c_cfg.line_packed;
  assign surf_packed     = w_c_cfg.surf_packed;
  assign clip_truncate   = w_c_cfg.clip;
  assign cya             = w_c_cfg.cya;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_cacc_grp_reg.sv
`default_nettype none
// Bench for nv_nvdla_cacc_grp_reg: 2-group instance (A) and 4-group instance (B).
module tb_nv_nvdla_cacc_grp_reg;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        do_wr;
    logic [11:0] ofs;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[$];

  logic [31:0] rd;
  logic [31:0] exp_sat;
  logic [31:0] exp_sat_clr;

  logic [11:0] a_ofs;   logic a_wr;  logic [31:0] a_wdata; logic [31:0] a_rdata;
  logic a_done;         logic [31:0] a_sat;
  logic a_op_en;        logic a_cons; logic a_dintr; logic a_dgrp;
  logic a_conv;         logic [1:0] a_prec;
  logic [12:0] a_w, a_h, a_c; logic [26:0] a_addr; logic [4:0] a_batch;
  logic [23:0] a_ls, a_ss; logic a_lp, a_sp; logic [4:0] a_clip; logic [31:0] a_cya;

  logic [11:0] b_ofs;   logic b_wr;  logic [31:0] b_wdata; logic [31:0] b_rdata;
  logic b_done;         logic [31:0] b_sat;
  logic b_op_en;        logic [1:0] b_cons; logic b_dintr; logic [1:0] b_dgrp;
  logic b_conv;         logic [1:0] b_prec;
  logic [14:0] b_w, b_h, b_c; logic [26:0] b_addr; logic [4:0] b_batch;
  logic [23:0] b_ls, b_ss; logic b_lp, b_sp; logic [4:0] b_clip; logic [31:0] b_cya;

  nv_nvdla_cacc_grp_reg #(.NUM_GROUPS(2), .PTR_W(1), .CH_W(13)) u_dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .reg_offset(a_ofs), .reg_wr_en(a_wr), .reg_wr_data(a_wdata), .reg_rd_data(a_rdata),
    .dp_op_done(a_done), .sat_count(a_sat),
    .op_en(a_op_en), .consumer(a_cons), .done_intr(a_dintr), .done_grp(a_dgrp),
    .conv_mode(a_conv), .proc_precision(a_prec),
    .dataout_width(a_w), .dataout_height(a_h), .dataout_channel(a_c),
    .dataout_addr(a_addr), .batches(a_batch), .line_stride(a_ls), .surf_stride(a_ss),
    .line_packed(a_lp), .surf_packed(a_sp), .clip_truncate(a_clip), .cya(a_cya)
  );

  nv_nvdla_cacc_grp_reg #(.NUM_GROUPS(4), .PTR_W(2), .CH_W(15)) u_dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .reg_offset(b_ofs), .reg_wr_en(b_wr), .reg_wr_data(b_wdata), .reg_rd_data(b_rdata),
    .dp_op_done(b_done), .sat_count(b_sat),
    .op_en(b_op_en), .consumer(b_cons), .done_intr(b_dintr), .done_grp(b_dgrp),
    .conv_mode(b_conv), .proc_precision(b_prec),
    .dataout_width(b_w), .dataout_height(b_h), .dataout_channel(b_c),
    .dataout_addr(b_addr), .batches(b_batch), .line_stride(b_ls), .surf_stride(b_ss),
    .line_packed(b_lp), .surf_packed(b_sp), .clip_truncate(b_clip), .cya(b_cya)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_a(input logic [11:0] o, input logic [31:0] d);
    a_ofs = o; a_wdata = d; a_wr = 1'b1;
    @(negedge clk);
    a_wr = 1'b0;
  endtask

  task automatic rd_a(input logic [11:0] o, output logic [31:0] d);
    a_ofs = o; #1; d = a_rdata;
    @(negedge clk);
  endtask

  task automatic done_a(input logic [31:0] s);
    a_done = 1'b1; a_sat = s;
    @(negedge clk);
    a_done = 1'b0;
  endtask

  task automatic wr_b(input logic [11:0] o, input logic [31:0] d);
    b_ofs = o; b_wdata = d; b_wr = 1'b1;
    @(negedge clk);
    b_wr = 1'b0;
  endtask

  task automatic rd_b(input logic [11:0] o, output logic [31:0] d);
    b_ofs = o; #1; d = b_rdata;
    @(negedge clk);
  endtask

  task automatic done_b(input logic [31:0] s);
    b_done = 1'b1; b_sat = s;
    @(negedge clk);
    b_done = 1'b0;
  endtask

  // Program group g on A, let it reach RUN, then finish it with sat count s.
  task automatic run_op_a(input logic [31:0] g, input logic [31:0] s);
    chk("run_cons_pre", 32'(a_cons), g);
    wr_a(12'h000, g);
    wr_a(12'h008, 32'h1);
    step(1);
    chk("run_op_en", 32'(a_op_en), 32'h1);
    done_a(s);
  endtask

  initial begin
    a_ofs = '0; a_wr = 1'b0; a_wdata = '0; a_done = 1'b0; a_sat = '0;
    b_ofs = '0; b_wr = 1'b0; b_wdata = '0; b_done = 1'b0; b_sat = '0;

    // reset reads, then write/readback on group 1 of A (pointer write wraps 3 -> 1)
    tbl.push_back('{1'b0, 12'h000, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h004, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h008, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h00c, 32'h0, 32'h0000_1000});
    tbl.push_back('{1'b0, 12'h010, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h014, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h018, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h01c, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h020, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h024, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h028, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h02c, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h030, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h034, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h038, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'hffc, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 12'h000, 32'hffff_fff3, 32'h0000_0001});
    tbl.push_back('{1'b1, 12'h00c, 32'hffff_ffff, 32'h0000_3001});
    tbl.push_back('{1'b1, 12'h010, 32'hffff_ffff, 32'h1fff_1fff});
    tbl.push_back('{1'b1, 12'h014, 32'hffff_ffff, 32'h0000_1fff});
    tbl.push_back('{1'b1, 12'h018, 32'h0000_001f, 32'h0000_0000});
    tbl.push_back('{1'b1, 12'h01c, 32'hffff_ffff, 32'h0000_001f});
    tbl.push_back('{1'b1, 12'h020, 32'hffff_ffff, 32'h00ff_ffff});
    tbl.push_back('{1'b1, 12'h024, 32'h0123_4567, 32'h0023_4567});
    tbl.push_back('{1'b1, 12'h028, 32'hffff_ffff, 32'h0001_0001});
    tbl.push_back('{1'b1, 12'h02c, 32'h0001_2345, 32'h0000_0005});
    tbl.push_back('{1'b1, 12'h030, 32'hffff_ffff, 32'h0000_0000});
    tbl.push_back('{1'b1, 12'h034, 32'ha5a5_5a5a, 32'ha5a5_5a5a});
    tbl.push_back('{1'b1, 12'h038, 32'hffff_ffff, 32'h0000_0000});
    tbl.push_back('{1'b1, 12'h000, 32'h0000_0000, 32'h0000_0000});
    tbl.push_back('{1'b0, 12'h00c, 32'h0, 32'h0000_1000});
    tbl.push_back('{1'b0, 12'h004, 32'h0, 32'h0000_0000});

    step(3);
    rstn = 1'b1;

    chk("rst_op_en", 32'(a_op_en), 32'h0);
    chk("rst_consumer", 32'(a_cons), 32'h0);
    chk("rst_done_intr", 32'(a_dintr), 32'h0);
    chk("rst_done_grp", 32'(a_dgrp), 32'h0);
    chk("rst_precision", 32'(a_prec), 32'h1);

    foreach (tbl[i]) begin
      if (tbl[i].do_wr) wr_a(tbl[i].ofs, tbl[i].wdata);
      rd_a(tbl[i].ofs, rd);
      chk($sformatf("tbl[%0d] ofs 0x%03h", i, tbl[i].ofs), rd, tbl[i].exp_rd);
    end

    // group 0 config and start
    wr_a(12'h018, 32'hdead_bee0);
    chk("dataout_addr", 32'(a_addr), 32'h06f5_6df7);
    wr_a(12'h010, 32'h0040_0020);
    chk("dataout_width", 32'(a_w), 32'h20);
    chk("dataout_height", 32'(a_h), 32'h40);
    wr_a(12'h008, 32'h1);
    chk("op_en_pend", 32'(a_op_en), 32'h0);
    step(1);
    chk("op_en_run", 32'(a_op_en), 32'h1);
    rd_a(12'h004, rd);
    chk("status_run0", rd, 32'h2);

    // locked write
    wr_a(12'h000, 32'h0);
    wr_a(12'h02c, 32'h5);
    rd_a(12'h02c, rd);
    chk("locked_clip", rd, 32'h0);
    rd_a(12'h004, rd);
    chk("wr_err_set", rd, 32'h8000_0002);
    wr_a(12'h004, 32'h8000_0000);
    rd_a(12'h004, rd);
    chk("wr_err_clr", rd, 32'h2);

    // group 1 pending behind group 0
    wr_a(12'h000, 32'h1);
    wr_a(12'h008, 32'h1);
    rd_a(12'h004, rd);
    chk("status_pend1", rd, 32'h6);
    done_a(32'h7);
    chk("d0_done_intr", 32'(a_dintr), 32'h1);
    chk("d0_done_grp", 32'(a_dgrp), 32'h0);
    chk("d0_consumer", 32'(a_cons), 32'h1);
    chk("d0_op_en_low", 32'(a_op_en), 32'h0);
    step(1);
    chk("d0_op_en_high", 32'(a_op_en), 32'h1);
    chk("d0_intr_pulse", 32'(a_dintr), 32'h0);
    chk("g1_cya", a_cya, 32'ha5a5_5a5a);
    chk("g1_precision", 32'(a_prec), 32'h3);
    chk("g1_channel", 32'(a_c), 32'h1fff);
    wr_a(12'h000, 32'h0);
    rd_a(12'h030, rd);
    chk("sat_g0", rd, 32'h7);

    // done on group 1 together with OP_ENABLE on idle group 0
    a_done = 1'b1; a_sat = 32'h11;
    wr_a(12'h008, 32'h1);
    a_done = 1'b0;
    chk("sim_consumer", 32'(a_cons), 32'h0);
    chk("sim_done_intr", 32'(a_dintr), 32'h1);
    chk("sim_done_grp", 32'(a_dgrp), 32'h1);
    step(1);
    chk("sim_op_en", 32'(a_op_en), 32'h1);
    rd_a(12'h004, rd);
    chk("sim_status", rd, 32'h2);
    wr_a(12'h000, 32'h1);
    rd_a(12'h030, rd);
    chk("sat_g1", rd, 32'h11);

    // done on group 0 together with a write to group 0: write dropped
    wr_a(12'h000, 32'h0);
    a_done = 1'b1; a_sat = 32'h0;
    wr_a(12'h02c, 32'h9);
    a_done = 1'b0;
    chk("same_consumer", 32'(a_cons), 32'h1);
    rd_a(12'h02c, rd);
    chk("same_clip", rd, 32'h0);
    rd_a(12'h004, rd);
    chk("same_status", rd, 32'h8000_0000);

    // done while consumer idle is ignored
    done_a(32'h55);
    chk("idle_done_intr", 32'(a_dintr), 32'h0);
    chk("idle_consumer", 32'(a_cons), 32'h1);

    wr_a(12'h004, 32'h8000_0000);
    run_op_a(32'h1, 32'h0);
    run_op_a(32'h0, 32'hffff_fff0);
    run_op_a(32'h1, 32'h0);
    run_op_a(32'h0, 32'h20);
`ifdef NVDLA_CACC_SAT_ACCUM_EN
    exp_sat     = 32'hffff_ffff;
    exp_sat_clr = 32'h0;
`else
    exp_sat     = 32'h20;
    exp_sat_clr = 32'h20;
`endif
    rd_a(12'h030, rd);
    chk("sat_accum", rd, exp_sat);
    wr_a(12'h030, 32'h1234);
    rd_a(12'h030, rd);
    chk("sat_write", rd, exp_sat_clr);

    // 4-group instance: round robin 0,1,2,3,0
    rd_b(12'h00c, rd);
    chk("b_rst_misc", rd, 32'h1000);
    chk("b_rst_op_en", 32'(b_op_en), 32'h0);
    for (int g = 0; g < 4; g++) begin
      wr_b(12'h000, 32'(g));
      wr_b(12'h008, 32'h1);
    end
    rd_b(12'h004, rd);
    chk("b_status_all", rd, 32'h56);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_cons_%0d", i), 32'(b_cons), 32'(i));
      chk($sformatf("b_op_en_%0d", i), 32'(b_op_en), 32'h1);
      done_b(32'(i));
      chk($sformatf("b_done_grp_%0d", i), 32'(b_dgrp), 32'(i));
      chk($sformatf("b_done_intr_%0d", i), 32'(b_dintr), 32'h1);
      chk($sformatf("b_cons_next_%0d", i), 32'(b_cons), 32'((i + 1) % 4));
      step(1);
    end
    chk("b_op_en_end", 32'(b_op_en), 32'h0);
    done_b(32'h0);
    chk("b_idle_done", 32'(b_dintr), 32'h0);
    wr_b(12'h000, 32'h7);
    rd_b(12'h000, rd);
    chk("b_ptr_wrap", rd, 32'h3);
    wr_b(12'h010, 32'hffff_ffff);
    rd_b(12'h010, rd);
    chk("b_size_ch15", rd, 32'h7fff_7fff);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
